nx_stream_combiner: RTL

Merges the two outbound message sources of a node onto its four directional egress links. Source one is the bypass stream from the inbound stream arbiter: traffic passing through this node. Source two is the node's own emitted message stream. The block applies weighted round-robin between the two sources only when both target the same direction in the same cycle, and registers every egress link through a single-entry holding slot.

---
 rtl/nx_stream_combiner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nx_stream_combiner.sv
// nx_stream_combiner: merges the bypass (through-traffic) and emit (local)
// message streams onto four registered directional egress slots, with a
// weighted round-robin that only engages when both sources contend for the
// same free slot in the same cycle.

package nx_pkg;
    typedef enum logic [1:0] {
        NX_NORTH = 2'd0,
        NX_EAST  = 2'd1,
        NX_SOUTH = 2'd2,
        NX_WEST  = 2'd3
    } nx_direction_t;

    typedef struct packed {
        logic [7:0]  hdr;
        logic [23:0] payload;
    } nx_message_t;
endpackage

// Single-entry egress holding slot: load wins over drain, data holds otherwise.
module nx_combiner_slot
    import nx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  nx_message_t load_data_i,
    input  logic        drain_i,
    output logic        valid_o,
    output nx_message_t data_o
);
    logic        valid_q, valid_d;
    nx_message_t data_q, data_d;

    // Next state: a load replaces the entry (no bubble on drain+load).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any held message.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

module nx_stream_combiner
    import nx_pkg::*;
#(
    parameter int unsigned BYPASS_WEIGHT = 1,
    parameter int unsigned EMIT_WEIGHT   = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  nx_message_t   bypass_data_i,
    input  nx_direction_t bypass_dir_i,
    input  logic          bypass_valid_i,
    output logic          bypass_ready_o,
    input  nx_message_t   emit_data_i,
    input  nx_direction_t emit_dir_i,
    input  logic          emit_valid_i,
    output logic          emit_ready_o,
    output nx_message_t   north_data_o,
    output logic          north_valid_o,
    input  logic          north_ready_i,
    output nx_message_t   east_data_o,
    output logic          east_valid_o,
    input  logic          east_ready_i,
    output nx_message_t   south_data_o,
    output logic          south_valid_o,
    input  logic          south_ready_i,
    output nx_message_t   west_data_o,
    output logic          west_valid_o,
    input  logic          west_ready_i,
    output logic          idle_o
);
    localparam int NUM_DIRS = 4;
    localparam logic [3:0] BW = 4'(BYPASS_WEIGHT);
    localparam logic [3:0] EW = 4'(EMIT_WEIGHT);

    logic [NUM_DIRS-1:0] egress_rdy;
    logic [NUM_DIRS-1:0] valid_q;
    logic [NUM_DIRS-1:0] slot_free;
    nx_message_t         data_q [NUM_DIRS];

    logic       owner_q, owner_d;   // 0 = bypass, 1 = emit
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       contest;
    logic       gnt_b, gnt_e;

    assign egress_rdy = {west_ready_i, south_ready_i, east_ready_i, north_ready_i};
    assign slot_free  = ~valid_q | egress_rdy;

    // Contention only matters when the shared target slot could actually load.
    assign contest = bypass_valid_i && emit_valid_i &&
                     (bypass_dir_i == emit_dir_i) && slot_free[bypass_dir_i];

    assign bypass_ready_o = slot_free[bypass_dir_i] && !(contest && owner_q);
    assign emit_ready_o   = slot_free[emit_dir_i]   && !(contest && !owner_q);

    assign gnt_b = bypass_valid_i && bypass_ready_o;
    assign gnt_e = emit_valid_i && emit_ready_o;

    // Arbiter next state: only contested cycles advance the weight counter.
    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 4'd1;
        if (contest) begin
            if (cnt_inc == (owner_q ? EW : BW)) begin
                owner_d = ~owner_q;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Arbiter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // One holding slot per direction; at most one source is granted per slot.
    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_slot
        logic hit_b, hit_e;
        assign hit_b = gnt_b && (bypass_dir_i == nx_direction_t'(d));
        assign hit_e = gnt_e && (emit_dir_i == nx_direction_t'(d));

        nx_combiner_slot u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (hit_b || hit_e),
            .load_data_i (hit_b ? bypass_data_i : emit_data_i),
            .drain_i     (egress_rdy[d]),
            .valid_o     (valid_q[d]),
            .data_o      (data_q[d])
        );
    end

    assign north_valid_o = valid_q[0];
    assign east_valid_o  = valid_q[1];
    assign south_valid_o = valid_q[2];
    assign west_valid_o  = valid_q[3];
    assign north_data_o  = data_q[0];
    assign east_data_o   = data_q[1];
    assign south_data_o  = data_q[2];
    assign west_data_o   = data_q[3];

    assign idle_o = (valid_q == '0) && !bypass_valid_i && !emit_valid_i;
endmodule
